// File: rtl/ahb_pkg.sv
// AHB slave shared definitions.
// Transfer/response codes and the SRAM bridge FSM states.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_e;

endpackage

// File: rtl/ahb_sram_slave.sv
// AHB-Lite word-only slave bridging to a start/io_done SRAM port.
// Fixed four-cycle minimum data phase; illegal transfers get a 2-cycle ERROR.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADYIN,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP,
  output logic              start,
  output logic              writemode,
  output logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_w_data,
  input  logic [DATA_W-1:0] i_r_data,
  input  logic              io_done
);

  state_e              state_q, state_d;
  logic                hwrite_q;
  logic                start_q;
  logic                writemode_q;
  logic [ADDR_W-1:0]   i_address_q;
  logic [DATA_W-1:0]   i_w_data_q;
  logic [DATA_W-1:0]   hrdata_q;
  logic                hready_c;
  logic [1:0]          hresp_c;

  logic                accept;
  logic                illegal;
  logic                can_accept;
  logic [31:0]         hi_bits;

  assign hi_bits = HADDR >> (ADDR_W + 2);

  assign accept = HSEL && HREADYIN &&
                  (HTRANS == HTRANS_NONSEQ ||
                   HTRANS == HTRANS_SEQ);

  assign illegal = (HSIZE != HSIZE_WORD) ||
                   (HADDR[1:0] != 2'b00) ||
                   (hi_bits != 32'd0);

  assign can_accept = (state_q == ST_IDLE) ||
                      (state_q == ST_DONE) ||
                      (state_q == ST_ERR2);

  // Next state and bus response decode from the current state.
  always_comb begin
    state_d  = state_q;
    hready_c = 1'b1;
    hresp_c  = HRESP_OKAY;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (state_q == ST_ERR2) hresp_c = HRESP_ERROR;
        state_d = ST_IDLE;
        if (accept) state_d = illegal ? ST_ERR1 : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        hready_c = 1'b0;
        state_d  = ST_ISSUE;
      end
      ST_ISSUE: begin
        hready_c = 1'b0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        hready_c = 1'b0;
        if (io_done) state_d = ST_DONE;
      end
      ST_ERR1: begin
        hready_c = 1'b0;
        hresp_c  = HRESP_ERROR;
        state_d  = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request registers and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hwrite_q    <= 1'b0;
      start_q     <= 1'b0;
      writemode_q <= 1'b0;
      i_address_q <= '0;
      i_w_data_q  <= '0;
      hrdata_q    <= '0;
    end else begin
      state_q <= state_d;
      start_q <= (state_q == ST_CAPTURE);
      if (can_accept && accept && !illegal) begin
        hwrite_q    <= HWRITE;
        i_address_q <= HADDR[ADDR_W+1:2];
      end
      if (state_q == ST_CAPTURE) begin
        writemode_q <= hwrite_q;
        if (hwrite_q) i_w_data_q <= HWDATA;
      end
      if (state_q == ST_WAIT && io_done && !hwrite_q)
        hrdata_q <= i_r_data;
    end
  end

  assign HREADYOUT = hready_c;
  assign HRESP     = hresp_c;
  assign HRDATA    = hrdata_q;
  assign start     = start_q;
  assign writemode = writemode_q;
  assign i_address = i_address_q;
  assign i_w_data  = i_w_data_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: per-cycle expectation table built from
// transaction-level rules, compared against the DUT every cycle.
module tb_ahb_sram_slave;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          hsel;
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [DW-1:0] hwdata;
  logic          hreadyin;
  logic [DW-1:0] hrdata;
  logic          hreadyout;
  logic [1:0]    hresp;
  logic          start;
  logic          writemode;
  logic [AW-1:0] i_address;
  logic [DW-1:0] i_w_data;
  logic [DW-1:0] i_r_data;
  logic          io_done;

  ahb_sram_slave #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .HSEL(hsel), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HWDATA(hwdata), .HREADYIN(hreadyin), .HRDATA(hrdata),
    .HREADYOUT(hreadyout), .HRESP(hresp), .start(start),
    .writemode(writemode), .i_address(i_address),
    .i_w_data(i_w_data), .i_r_data(i_r_data), .io_done(io_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rdy;
    bit [1:0]    resp;
    bit          st;
    bit          chk;
    bit          wm;
    bit [AW-1:0] addr;
    bit [DW-1:0] wd;
    bit          set_hr;
    bit [DW-1:0] hr;
  } exp_t;

  exp_t          ea[int];
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  bit [DW-1:0]   m_hr = '0;
  bit [DW-1:0]   m_wd = '0;
  bit            rdyin = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t blank();
    exp_t e;
    e.rdy = 1; e.resp = 0; e.st = 0; e.chk = 0;
    e.wm = 0; e.addr = 0; e.wd = 0; e.set_hr = 0; e.hr = 0;
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // compare DUT against the expectation table on every cycle
  always @(negedge clk) begin
    exp_t e;
    if (cyc >= 1) begin
      if (ea.exists(cyc)) e = ea[cyc];
      else e = blank();
      chk("hreadyout", {31'd0, hreadyout}, {31'd0, e.rdy});
      chk("hresp", {30'd0, hresp}, {30'd0, e.resp});
      chk("start", {31'd0, start}, {31'd0, e.st});
      if (e.set_hr) m_hr = e.hr;
      chk("hrdata", hrdata, m_hr);
      if (e.chk) begin
        chk("writemode", {31'd0, writemode}, {31'd0, e.wm});
        chk("i_address", {16'd0, i_address}, {16'd0, e.addr});
        chk("i_w_data", i_w_data, e.wd);
      end
    end
  end

  task automatic set_in(bit sel, bit [1:0] tr, bit wr,
                        bit [2:0] sz, bit [31:0] ad,
                        bit [31:0] wd, bit dn,
                        bit [31:0] rd, bit r);
    hsel = sel; htrans = tr; hwrite = wr; hsize = sz;
    haddr = ad; hwdata = wd; io_done = dn; i_r_data = rd;
    rst = r; hreadyin = rdyin;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit sel, bit [1:0] tr, bit wr,
                       bit [2:0] sz, bit [31:0] ad,
                       bit [31:0] wd, bit dn,
                       bit [31:0] rd, bit r);
    set_in(sel, tr, wr, sz, ad, wd, dn, rd, r);
    tick();
  endtask

  task automatic idle(int n);
    repeat (n) drive(0, 2'b00, 0, 3'b000, 0, 0, 0, 0, 0);
  endtask

  // One transfer starting with its address phase in the current cycle.
  // Returns at the start of the DONE (or ERR2) cycle.
  task automatic xfer(bit wr, bit [31:0] ad, bit [2:0] sz,
                      bit [31:0] wd, bit [31:0] rd, int lat,
                      bit [1:0] tr);
    int   c;
    bit   legal;
    exp_t e;
    c = cyc;
    legal = (sz == 3'b010) && (ad % 4 == 0) &&
            (ad < (32'd1 << (AW + 2)));
    if (!legal) begin
      e = blank(); e.rdy = 0; e.resp = 2'b01; ea[c+1] = e;
      e.rdy = 1; ea[c+2] = e;
      drive(1, tr, wr, sz, ad, ~wd, 0, 0, 0);
      drive(0, 2'b00, 0, 0, 0, wd, 0, 0, 0);
      return;
    end
    if (wr) m_wd = wd;
    e = blank(); e.rdy = 0; ea[c+1] = e;
    e.st = 1; e.chk = 1; e.wm = wr;
    e.addr = AW'(ad / 4); e.wd = m_wd;
    ea[c+2] = e;
    e.st = 0;
    for (int i = 0; i <= lat; i++) ea[c+3+i] = e;
    e.rdy = 1;
    if (!wr) begin e.set_hr = 1; e.hr = rd; end
    ea[c+4+lat] = e;
    drive(1, tr, wr, sz, ad, ~wd, 0, 0, 0);
    drive(0, 2'b00, 0, 0, 0, wd, 0, 0, 0);
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    repeat (lat) drive(0, 2'b00, 0, 0, 0, 0, 0, ~rd, 0);
    drive(0, 2'b00, 0, 0, 0, 0, 1, rd, 0);
  endtask

  // Read interrupted by reset in its first WAIT cycle.
  task automatic rst_mid();
    int   c;
    exp_t e;
    c = cyc;
    e = blank(); e.rdy = 0; ea[c+1] = e;
    e.st = 1; e.chk = 1; e.wm = 0; e.addr = 2; e.wd = m_wd;
    ea[c+2] = e;
    e.st = 0; ea[c+3] = e;
    e = blank(); e.chk = 1; e.set_hr = 1; e.hr = 0; ea[c+4] = e;
    ea[c+5] = e;
    m_wd = 0;
    drive(1, 2'b10, 0, 3'b010, 32'h8, 0, 0, 0, 0);
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 2'b00, 0, 0, 0, 0, 1, 32'h55, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    e = blank(); e.chk = 1; e.set_hr = 1; e.hr = 0;
    ea[1] = e; ea[2] = e;
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    // no-op address phases: BUSY, unselected, HREADYIN low, IDLE
    drive(1, 2'b01, 1, 3'b010, 32'h4, 0, 0, 0, 0);
    drive(0, 2'b10, 1, 3'b010, 32'h4, 0, 0, 0, 0);
    rdyin = 0;
    drive(1, 2'b10, 1, 3'b010, 32'h4, 0, 0, 0, 0);
    rdyin = 1;
    drive(1, 2'b00, 1, 3'b010, 32'h4, 0, 0, 0, 0);

    xfer(1, 32'h4, 3'b010, 32'hAF, 0, 0, 2'b10);
    set_in(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lit_wr_rdy", {31'd0, hreadyout}, 32'd1);
    chk("lit_wr_addr", {16'd0, i_address}, 32'd1);
    chk("lit_wr_data", i_w_data, 32'hAF);
    chk("lit_wr_mode", {31'd0, writemode}, 32'd1);
    tick();
    idle(1);

    xfer(0, 32'h4, 3'b010, 0, 32'hAF, 1, 2'b10);
    set_in(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lit_rd_data", hrdata, 32'hAF);
    chk("lit_rd_rdy", {31'd0, hreadyout}, 32'd1);
    chk("lit_rd_resp", {30'd0, hresp}, 32'd0);
    tick();

    xfer(1, 32'h4, 3'b000, 32'h11, 0, 0, 2'b10);
    set_in(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lit_err2_resp", {30'd0, hresp}, 32'd1);
    chk("lit_err2_rdy", {31'd0, hreadyout}, 32'd1);
    tick();
    xfer(0, 32'h2, 3'b010, 0, 0, 0, 2'b10);
    idle(1);
    xfer(1, 32'h0004_0000, 3'b010, 32'h22, 0, 0, 2'b10);
    idle(1);

    // back-to-back chain, including accept during ERR2
    xfer(1, 32'h10, 3'b010, 32'h1234_5678, 0, 0, 2'b10);
    xfer(0, 32'h10, 3'b010, 0, 32'hCAFE_F00D, 2, 2'b10);
    xfer(1, 32'h3_FFFC, 3'b010, 32'hFFFF_0001, 0, 0, 2'b11);
    xfer(0, 32'h2, 3'b010, 0, 0, 0, 2'b10);
    xfer(0, 32'h8, 3'b010, 0, 32'h0BAD_BEEF, 0, 2'b11);
    idle(2);

    // stray io_done while idle
    drive(0, 2'b00, 0, 0, 0, 0, 1, 32'hDEAD_DEAD, 0);
    idle(2);

    rst_mid();
    idle(2);
    xfer(0, 32'h4, 3'b010, 0, 32'h600D, 0, 2'b10);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
